// File: rtl/adder_seq_pkg.sv
// Shared definitions for the serial adder slice sequencer.
// Contents: slice width constant, FSM state encoding and requester-id type.
package adder_seq_pkg;

  // Width of the shared ripple-carry adder slice.
  localparam int unsigned SLICE_W = 3;

  // Sequencer FSM state encoding.
  typedef logic [1:0] state_t;
  localparam state_t StIdle = 2'd0;
  localparam state_t StRun  = 2'd1;
  localparam state_t StDone = 2'd2;

  // Identifies which of the two requesters issued an operation.
  typedef logic req_id_t;

endpackage

// File: rtl/adder_slice3.sv
// Purely combinational 3-bit ripple-carry adder slice; the shared resource.
// Ports:
//   a, b  - 3-bit operand slices
//   cin   - carry into bit 0
//   sum   - 3-bit slice sum
//   cout  - carry out of bit 2
module adder_slice3 (
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic       cin,
  output logic [2:0] sum,
  output logic       cout
);

  logic c1;
  logic c2;

  assign sum[0] = a[0] ^ b[0] ^ cin;
  assign c1     = (a[0] & b[0]) | (a[0] & cin) | (b[0] & cin);
  assign sum[1] = a[1] ^ b[1] ^ c1;
  assign c2     = (a[1] & b[1]) | (a[1] & c1) | (b[1] & c1);
  assign sum[2] = a[2] ^ b[2] ^ c2;
  assign cout   = (a[2] & b[2]) | (a[2] & c2) | (b[2] & c2);

endmodule

// File: rtl/adder_slice_sequencer.sv
// Arbitrates two requesters onto one 3-bit adder slice and runs each WIDTH-bit
// add serially, LSB slice first, chaining the carry between slices.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   reqN_valid / reqN_ready     - request handshake (ready is combinational)
//   reqN_a, reqN_b, reqN_cin    - operands, sampled only on the grant cycle
//   rsp_valid / rsp_ready       - response handshake
//   rsp_sum, rsp_cout, rsp_id   - registered result, carry-out, requester id
module adder_slice_sequencer
  import adder_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id
);

  localparam int unsigned SLICES = WIDTH / SLICE_W;
  localparam int unsigned IdxW   = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(SLICES - 1);

  if (WIDTH == 0 || (WIDTH % SLICE_W) != 0) begin : g_width_check
    $error("adder_slice_sequencer: WIDTH must be a positive multiple of 3");
  end

  state_t          state_q, state_d;
  req_id_t         ptr_q, ptr_d;
  req_id_t         id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_cout_q, rsp_cout_d;
  req_id_t          rsp_id_q, rsp_id_d;

  logic            grant;
  req_id_t         grant_id;
  logic [2:0]      slice_a;
  logic [2:0]      slice_b;
  logic [2:0]      slice_sum;
  logic            slice_cout;

  // Grant is suppressed during reset so no request is acknowledged then.
  assign grant    = (state_q == StIdle) && !rst && (req0_valid || req1_valid);
  assign grant_id = (req0_valid && req1_valid) ? ptr_q : req_id_t'(req1_valid);

  assign req0_ready = grant && (grant_id == 1'b0);
  assign req1_ready = grant && (grant_id == 1'b1);

  assign slice_a = a_q[idx_q * SLICE_W +: SLICE_W];
  assign slice_b = b_q[idx_q * SLICE_W +: SLICE_W];

  adder_slice3 u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    work_d      = work_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_id_d    = rsp_id_q;

    unique case (state_q)
      StIdle: begin
        if (grant) begin
          a_d     = grant_id ? req1_a : req0_a;
          b_d     = grant_id ? req1_b : req0_b;
          carry_d = grant_id ? req1_cin : req0_cin;
          id_d    = grant_id;
          ptr_d   = ~grant_id;
          idx_d   = '0;
          work_d  = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        work_d[idx_q * SLICE_W +: SLICE_W] = slice_sum;
        carry_d = slice_cout;
        if (idx_q == LastIdx) begin
          // Response registers load only here, so they hold the previous
          // result for the whole of the next operation's RUN phase.
          rsp_valid_d = 1'b1;
          rsp_sum_d   = work_d;
          rsp_cout_d  = slice_cout;
          rsp_id_d    = id_q;
          state_d     = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= 1'b0;
      id_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      work_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      work_q      <= work_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_adder_slice_sequencer.sv
// Scoreboard bench for adder_slice_sequencer (WIDTH = 12).
// Stimulus pushes the hand-computed response in the order the arbiter should
// serve it; a separate monitor pops and compares on every response handshake.
module tb_adder_slice_sequencer;

  localparam int unsigned W = 12;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         id;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req0_cin;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_cin;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_cout, rsp_id;
  logic [W-1:0] rsp_sum;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rsp_count = 0;

  always #5 clk = ~clk;

  adder_slice_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_id     (rsp_id)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every delivered response against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      check("ready_exclusive", {31'd0, req0_ready & req1_ready}, 32'd0);
      if (rsp_valid && rsp_ready) begin
        rsp_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_sum", {20'd0, rsp_sum}, {20'd0, e.sum});
          check("rsp_cout", {31'd0, rsp_cout}, {31'd0, e.cout});
          check("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
        end
      end
    end
  end

  // Present one request and hold it until accepted; returns just after the
  // accept edge with valid dropped.
  task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin);
    bit done = 0;
    if (id == 0) begin
      req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
    end
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if ((id == 0) ? req0_ready : req1_ready) done = 1;
      @(posedge clk);
      #1;
    end
    if (!done) check($sformatf("accept_timeout_req%0d", id), 32'd0, 32'd1);
    if (id == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] sum, input logic cout, input logic id);
    exp_t e;
    e.sum = sum; e.cout = cout; e.id = id;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    bit done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0) done = 1;
    end
    if (!done) check("drain_timeout", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [W-1:0] r0_a[3] = '{12'h111, 12'h7FF, 12'h0AB};
  logic [W-1:0] r0_b[3] = '{12'h222, 12'h801, 12'h0CD};
  logic         r0_c[3] = '{1'b0, 1'b0, 1'b1};
  logic [W-1:0] r0_s[3] = '{12'h333, 12'h000, 12'h179};
  logic         r0_o[3] = '{1'b0, 1'b1, 1'b0};
  logic [W-1:0] r1_a[3] = '{12'h999, 12'h001, 12'hF00};
  logic [W-1:0] r1_b[3] = '{12'h999, 12'h002, 12'h0FF};
  logic         r1_c[3] = '{1'b0, 1'b1, 1'b0};
  logic [W-1:0] r1_s[3] = '{12'h332, 12'h004, 12'hFFF};
  logic         r1_o[3] = '{1'b1, 1'b0, 1'b0};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved;
    rst = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 12'h001; req0_b = 12'h001; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = 12'h001; req1_b = 12'h001; req1_cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    // Reset state, with both valids high to show ready is gated.
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_sum", {20'd0, rsp_sum}, 32'd0);
    check("reset_rsp_cout", {31'd0, rsp_cout}, 32'd0);
    check("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
    check("reset_req0_ready", {31'd0, req0_ready}, 32'd0);
    check("reset_req1_ready", {31'd0, req1_ready}, 32'd0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single request with exact latency.
    push(12'h000, 1'b1, 1'b0);
    issue(0, 12'hFFF, 12'h001, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("latency_valid_c%0d", k), {31'd0, rsp_valid}, (k == 5) ? 32'd1 : 32'd0);
    end
    drain();

    // Simultaneous requests right after reset: requester 0 first.
    do_reset();
    push(12'h57A, 1'b0, 1'b0);
    push(12'h000, 1'b1, 1'b1);
    fork
      issue(0, 12'h123, 12'h456, 1'b1);
      issue(1, 12'h800, 12'h800, 1'b0);
    join
    drain();

    // Round-robin with both requesters continuously valid.
    for (int j = 0; j < 3; j++) begin
      push(r0_s[j], r0_o[j], 1'b0);
      push(r1_s[j], r1_o[j], 1'b1);
    end
    fork
      for (int j = 0; j < 3; j++) issue(0, r0_a[j], r0_b[j], r0_c[j]);
      for (int j = 0; j < 3; j++) issue(1, r1_a[j], r1_b[j], r1_c[j]);
    join
    drain();

    // Backpressure: hold the response for 10 cycles with req0 pending.
    rsp_ready = 1'b0;
    push(12'h100, 1'b0, 1'b1);
    issue(1, 12'h0FF, 12'h001, 1'b0);
    req0_a = 12'h7FF; req0_b = 12'h001; req0_cin = 1'b0; req0_valid = 1'b1;
    begin
      bit seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        if (rsp_valid) seen = 1;
      end
      if (!seen) check("bp_valid_timeout", 32'd0, 32'd1);
    end
    for (int c = 0; c < 10; c++) begin
      if (c != 0) @(negedge clk);
      check("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_sum", {20'd0, rsp_sum}, 32'h100);
      check("bp_cout", {31'd0, rsp_cout}, 32'd0);
      check("bp_id", {31'd0, rsp_id}, 32'd1);
      check("bp_ready_both", {30'd0, req0_ready, req1_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    push(12'h800, 1'b0, 1'b0);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Back in IDLE one cycle after the handshake: the pending req0 is granted.
    check("bp_idle_after_hs", {31'd0, req0_ready}, 32'd1);
    check("bp_valid_dropped", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    drain();

    // Full carry propagation and all-ones wrap-around.
    push(12'h000, 1'b1, 1'b0);
    issue(0, 12'hAAA, 12'h555, 1'b1);
    drain();
    push(12'hFFF, 1'b1, 1'b1);
    issue(1, 12'hFFF, 12'hFFF, 1'b1);
    drain();

    // Reset during slice 2: no response, outputs cleared, pointer back to 0.
    saved = rsp_count;
    issue(0, 12'h123, 12'h111, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_sum", {20'd0, rsp_sum}, 32'd0);
    check("mid_rst_cout", {31'd0, rsp_cout}, 32'd0);
    check("mid_rst_id", {31'd0, rsp_id}, 32'd0);
    repeat (10) @(negedge clk);
    check("mid_rst_no_rsp", rsp_count - saved, 32'd0);
    @(posedge clk);
    #1;
    push(12'h57A, 1'b0, 1'b0);
    push(12'h000, 1'b1, 1'b1);
    fork
      issue(1, 12'h800, 12'h800, 1'b0);
      issue(0, 12'h123, 12'h456, 1'b1);
    join
    drain();
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
